// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: NOP encoding, FSM state codes
// and the queue entry layout.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of fetched words. The head is a register, so the outputs
// carry no combinational path from the push side.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok, pop_ok;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);
    push_ok = push && ((count_q != 2'd2) || pop_ok);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop_ok) begin
        e0_d    = e1_q;
        count_d = count_q - 2'd1;
      end
      // Push lands in the first free slot after any pop has shifted the head.
      if (push_ok) begin
        if (count_d == 2'd0) begin
          e0_d = push_entry;
        end else begin
          e1_d = push_entry;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head  = e0_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch pointer, single-outstanding memory request FSM and
// a 2-entry output queue towards decode, with redirect flushing queue and in-flight fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  logic [1:0]   state_q, state_d;
  logic [31:0]  fetch_ptr_q, fetch_ptr_d;
  logic         q_push, q_full, q_empty, pop_ok;
  logic [1:0]   q_count;
  fetch_entry_t q_head, q_push_entry;

  assign pop_ok = instr_ready && !q_empty;
  // fetch_ptr advanced by exactly 4 on the handshake that launched the current fetch.
  assign q_push_entry = '{pc: fetch_ptr_q - 32'd4, instr: mem_resp_data};

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    q_push      = 1'b0;
    if (redirect_valid) begin
      fetch_ptr_d = {redirect_pc[31:2], 2'b00};
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ:  state_d = mem_req_ready ? ST_DRAIN : ST_REQ;
        // A response arriving alongside the redirect already retires the stale fetch.
        default: state_d = mem_resp_valid ? ST_REQ : ST_DRAIN;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (32'(q_count) < QUEUE_DEPTH) state_d = ST_REQ;
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state_d     = ST_WAIT;
            fetch_ptr_d = fetch_ptr_q + 32'd4;
          end
        end
        ST_WAIT: begin
          if (mem_resp_valid) begin
            q_push  = 1'b1;
            state_d = (q_empty || pop_ok) ? ST_REQ : ST_IDLE;
          end
        end
        default: begin
          if (mem_resp_valid) state_d = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      fetch_ptr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
    end
  end

  fetch_queue u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (q_push),
    .push_entry (q_push_entry),
    .pop        (instr_ready),
    .head       (q_head),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count)
  );

  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = fetch_ptr_q;
  assign instr_valid   = !q_empty;
  assign instr         = q_empty ? NOP_INSTR : q_head.instr;
  assign instr_pc      = q_empty ? 32'd0 : q_head.pc;

  a_resp_in_window: assert property (@(posedge clock) disable iff (reset)
    mem_resp_valid |-> (state_q == ST_WAIT || state_q == ST_DRAIN));

  a_wait_has_space: assert property (@(posedge clock) disable iff (reset)
    (state_q == ST_WAIT) |-> !q_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transaction-level reference model and a
// second instance exercising fetch-pointer wrap from a high reset address.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hDEAD_0000;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, redirect_valid, mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [31:0] redirect_pc, mem_req_addr, mem_resp_data, instr, instr_pc;
  logic        instr_valid, instr_ready;

  logic        reset2, mem_req_valid2, resp2_valid, instr_valid2;
  logic [31:0] mem_req_addr2, resp2_data, instr2, instr_pc2;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clock          (clock),
    .reset          (reset2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'd0),
    .mem_req_valid  (mem_req_valid2),
    .mem_req_addr   (mem_req_addr2),
    .mem_req_ready  (1'b1),
    .mem_resp_valid (resp2_valid),
    .mem_resp_data  (resp2_data),
    .instr_valid    (instr_valid2),
    .instr_ready    (1'b1),
    .instr          (instr2),
    .instr_pc       (instr_pc2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pointer, ordered queue of {pc, word}, request/outstanding flags.
  logic [31:0] m_ptr, m_out_pc;
  logic [63:0] m_q[$];
  bit          m_req, m_out, m_stale;

  // Memory environment and logs.
  int          latency = 1;
  int          edge_n = 0;
  bit          pend = 0;
  int          pend_edge = 0;
  logic [31:0] pend_addr;
  logic [31:0] acc_log[$];
  logic [63:0] cons_log[$];
  int          cons_cyc[$];

  bit          rst2 = 1'b1;
  bit          pend2 = 0;
  logic [31:0] pend2_addr;
  logic [31:0] acc2_log[$];
  bit          got2 = 0;
  logic [31:0] first_pc2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit redir, input logic [31:0] rpc,
                              input bit rdy, input bit irdy, input bit resp);
    bit hs;
    int size0;
    if (rst) begin
      m_ptr = 32'd0; m_q.delete(); m_req = 0; m_out = 0; m_stale = 0;
      return;
    end
    hs    = m_req && rdy;
    size0 = m_q.size();
    if (redir) begin
      m_q.delete();
      m_ptr = {rpc[31:2], 2'b00};
      if (hs) begin
        m_req = 0; m_out = 1; m_stale = 1;
      end else if (m_out) begin
        if (resp) begin m_out = 0; m_req = 1; end
        else m_stale = 1;
      end else begin
        m_req = 1;
      end
    end else begin
      if (irdy && size0 > 0) void'(m_q.pop_front());
      if (hs) begin
        m_out_pc = m_ptr; m_ptr = m_ptr + 32'd4; m_req = 0; m_out = 1; m_stale = 0;
      end else if (m_out && resp) begin
        m_out = 0;
        if (m_stale) m_req = 1;
        else begin
          m_q.push_back({m_out_pc, m_out_pc ^ SALT});
          m_req = (m_q.size() < 2);
        end
      end else if (!m_req && !m_out) begin
        m_req = (size0 < 2);
      end
    end
  endtask

  task automatic compare();
    chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, m_req});
    if (m_req) chk("mem_req_addr", mem_req_addr, m_ptr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_q.size() > 0});
    chk("instr", instr, (m_q.size() > 0) ? m_q[0][31:0] : NOP);
    chk("instr_pc", instr_pc, (m_q.size() > 0) ? m_q[0][63:32] : 32'd0);
  endtask

  // One clock: drive inputs, advance model, cross the posedge, compare at the negedge.
  task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input bit irdy);
    reset = rst; redirect_valid = redir; redirect_pc = rpc;
    mem_req_ready = rdy; instr_ready = irdy;
    mem_resp_valid = 1'b0; mem_resp_data = 32'd0;
    if (rst) pend = 0;
    else begin
      if (pend && pend_edge == edge_n) begin
        mem_resp_valid = 1'b1; mem_resp_data = pend_addr ^ SALT; pend = 0;
      end
      if (mem_req_valid === 1'b1 && rdy) begin
        pend = 1; pend_edge = edge_n + latency; pend_addr = mem_req_addr;
        acc_log.push_back(mem_req_addr);
      end
      if (instr_valid === 1'b1 && irdy) begin
        cons_log.push_back({instr_pc, instr});
        cons_cyc.push_back(edge_n);
      end
    end
    reset2 = rst2;
    resp2_valid = pend2; resp2_data = pend2_addr ^ SALT;
    if (!rst2 && mem_req_valid2 === 1'b1) begin
      pend2 = 1; pend2_addr = mem_req_addr2; acc2_log.push_back(mem_req_addr2);
    end else pend2 = 0;
    if (!rst2 && !got2 && instr_valid2 === 1'b1) begin got2 = 1; first_pc2 = instr_pc2; end
    model_update(rst, redir, rpc, rdy, irdy, mem_resp_valid);
    @(posedge clock);
    edge_n++;
    @(negedge clock);
    compare();
  endtask

  task automatic start_phase(input int lat);
    latency = lat;
    acc_log.delete(); cons_log.delete(); cons_cyc.delete();
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
  endtask

  initial begin
    bit stale_seen;
    int n;
    reset = 1; redirect_valid = 0; redirect_pc = 0; mem_req_ready = 0;
    mem_resp_valid = 0; mem_resp_data = 0; instr_ready = 0;
    reset2 = 1; resp2_valid = 0; resp2_data = 0; pend2_addr = 0; pend_addr = 0;
    @(negedge clock);

    // Phase 1: reset values, first request timing, streaming with 1-cycle memory.
    start_phase(1);
    rst2 = 0;
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 32'd0);
    step(0, 0, 0, 1, 1);
    chk("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("first_req_addr", mem_req_addr, 32'd0);
    repeat (12) step(0, 0, 0, 1, 1);
    chk("p1_acc_count", {31'd0, acc_log.size() >= 3}, 32'd1);
    chk("p1_cons_count", {31'd0, cons_log.size() >= 2}, 32'd1);
    if (acc_log.size() >= 3) begin
      chk("p1_acc0", acc_log[0], 32'h0);
      chk("p1_acc1", acc_log[1], 32'h4);
      chk("p1_acc2", acc_log[2], 32'h8);
    end
    if (cons_log.size() >= 2) begin
      chk("p1_cons0_pc", cons_log[0][63:32], 32'h0);
      chk("p1_cons0_instr", cons_log[0][31:0], 32'hDEAD_0000);
      chk("p1_cons1_pc", cons_log[1][63:32], 32'h4);
      chk("p1_cons1_instr", cons_log[1][31:0], 32'hDEAD_0004);
      chk("p1_spacing", 32'(cons_cyc[1] - cons_cyc[0]), 32'd2);
    end

    // Phase 2: decode stalled, queue fills and fetch stops; then drains and resumes at 0x8.
    start_phase(1);
    repeat (10) step(0, 0, 0, 1, 0);
    chk("p2_full_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("p2_full_instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("p2_full_head_pc", instr_pc, 32'h0);
    chk("p2_full_head", instr, 32'hDEAD_0000);
    n = 0;
    do begin step(0, 0, 0, 1, 1); n++; end while (mem_req_valid !== 1'b1 && n < 20);
    chk("p2_resume_timeout", {31'd0, mem_req_valid}, 32'd1);
    chk("p2_resume_addr", mem_req_addr, 32'h8);
    repeat (4) step(0, 0, 0, 1, 1);
    if (cons_log.size() >= 2) begin
      chk("p2_drain0", cons_log[0][63:32], 32'h0);
      chk("p2_drain1", cons_log[1][63:32], 32'h4);
    end else chk("p2_drain_count", 32'(cons_log.size()), 32'd2);

    // Phase 3: redirect during WAIT with a 3-cycle memory; stale word must be discarded.
    start_phase(3);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h100, 1, 1);
    chk("p3_redir_instr_valid", {31'd0, instr_valid}, 32'd0);
    repeat (20) step(0, 0, 0, 1, 1);
    chk("p3_acc1", (acc_log.size() >= 2) ? acc_log[1] : 32'hFFFF_FFFF, 32'h100);
    chk("p3_cons0_pc", (cons_log.size() >= 1) ? cons_log[0][63:32] : 32'hFFFF_FFFF, 32'h100);
    stale_seen = 0;
    foreach (cons_log[i]) if (cons_log[i][63:32] < 32'h100) stale_seen = 1;
    chk("p3_no_stale", {31'd0, stale_seen}, 32'd0);

    // Phase 4: redirect to unaligned target in the same cycle as the response.
    start_phase(1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h203, 1, 1);
    chk("p4_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("p4_req_addr", mem_req_addr, 32'h200);
    chk("p4_instr_valid", {31'd0, instr_valid}, 32'd0);
    repeat (8) step(0, 0, 0, 1, 1);
    chk("p4_cons0_pc", (cons_log.size() >= 1) ? cons_log[0][63:32] : 32'hFFFF_FFFF, 32'h200);

    // Phase 5: request held unaccepted, address stable; redirect retargets it.
    start_phase(1);
    n = 0;
    do begin step(0, 0, 0, 1, 1); n++; end
    while (!(mem_req_valid === 1'b1 && mem_req_addr == 32'h8) && n < 20);
    chk("p5_reach_timeout", mem_req_addr, 32'h8);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1);
      chk("p5_hold_addr", mem_req_addr, 32'h8);
    end
    step(0, 1, 32'h40, 0, 1);
    chk("p5_redir_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("p5_redir_addr", mem_req_addr, 32'h40);
    repeat (4) step(0, 0, 0, 1, 1);
    chk("p5_acc2", (acc_log.size() >= 3) ? acc_log[2] : 32'hFFFF_FFFF, 32'h40);

    // Wrap-around instance: started from 0xFFFF_FFF8 and has been streaming throughout.
    chk("wrap_acc_count", {31'd0, acc2_log.size() >= 3}, 32'd1);
    if (acc2_log.size() >= 3) begin
      chk("wrap_acc0", acc2_log[0], 32'hFFFF_FFF8);
      chk("wrap_acc1", acc2_log[1], 32'hFFFF_FFFC);
      chk("wrap_acc2", acc2_log[2], 32'h0000_0000);
    end
    chk("wrap_first_pc", got2 ? first_pc2 : 32'h1234_5678, 32'hFFFF_FFF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
